// File: rtl/h14tx_pkg.sv
// Shared types and constants for the HDMI 1.4 TX period scheduler.
package h14tx_pkg;

  typedef enum logic [1:0] {
    CTL   = 2'd0,
    PRE   = 2'd1,
    GUARD = 2'd2,
    VIDEO = 2'd3
  } period_t;

  typedef logic [1:0] ctl_t;

  localparam int LEAD         = 10;
  localparam int PREAMBLE_LEN = 8;
  localparam int GUARD_LEN    = 2;

  localparam ctl_t VIDEO_PREAMBLE_CTL1 = 2'b01;
  localparam ctl_t VIDEO_PREAMBLE_CTL2 = 2'b00;

endpackage

// File: rtl/h14tx_period_sched_if.sv
// Timing/pixel inputs and scheduled TMDS period outputs of h14tx_period_sched.
interface h14tx_period_sched_if #(parameter int PIXEL_W = 24);
  import h14tx_pkg::*;

  logic               de;
  logic               hsync;
  logic               vsync;
  logic [PIXEL_W-1:0] pixel;
  period_t            period;
  logic               de_o;
  logic [PIXEL_W-1:0] pixel_o;
  ctl_t               ctl0;
  ctl_t               ctl1;
  ctl_t               ctl2;
  logic               short_blank;

  modport master (
    output de, hsync, vsync, pixel,
    input  period, de_o, pixel_o, ctl0, ctl1, ctl2, short_blank
  );

  modport slave (
    input  de, hsync, vsync, pixel,
    output period, de_o, pixel_o, ctl0, ctl1, ctl2, short_blank
  );

endinterface

// File: rtl/h14tx_delay_line.sv
// Fixed-depth shift register; all stages clear to 0 on reset.
module h14tx_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [DEPTH-1:0][WIDTH-1:0] stage;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage <= '0;
    end else begin
      stage <= {stage[DEPTH-2:0], d};
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/h14tx_period_sched.sv
// TMDS period scheduler: delays video by LEAD+1 cycles and inserts preamble/guard band.
// Optional DVI mode (suppresses preamble/guard) is built with H14TX_DVI_MODE_EN.
//   state | meaning
//   CTL   | control period, ctl0 carries delayed {vsync,hsync}
//   PRE   | 8-cycle video preamble (ctl1=01)
//   GUARD | 2-cycle video guard band
//   VIDEO | active pixels while delayed de=1
module h14tx_period_sched
  import h14tx_pkg::*;
#(
  parameter int PIXEL_W = 24
) (
  input  logic clk,
  input  logic rst_n,
`ifdef H14TX_DVI_MODE_EN
  input  logic dvi,
`endif
  h14tx_period_sched_if.slave bus
);

  localparam int DW = PIXEL_W + 3;
  localparam logic [3:0] BLANK_MAX = 4'(LEAD);

  logic [DW-1:0]      dl_q;
  logic               de_d, hs_d, vs_d;
  logic [PIXEL_W-1:0] pix_d;
  logic               de_prev;
  logic [3:0]         blank_cnt;
  logic               rise, eligible, sb_nxt, dvi_eff;
  period_t            state, state_nxt, period_nxt;
  logic [2:0]         cnt, cnt_nxt;

  h14tx_delay_line #(.WIDTH(DW), .DEPTH(LEAD)) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({bus.de, bus.hsync, bus.vsync, bus.pixel}),
    .q     (dl_q)
  );

  assign de_d  = dl_q[DW-1];
  assign hs_d  = dl_q[DW-2];
  assign vs_d  = dl_q[DW-3];
  assign pix_d = dl_q[PIXEL_W-1:0];

  assign rise     = bus.de & ~de_prev;
  assign eligible = rise && (blank_cnt == BLANK_MAX);

`ifdef H14TX_DVI_MODE_EN
  logic dvi_q;

  // dvi is latched at the rise so it governs the whole preamble/guard sequence
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dvi_q <= 1'b0;
    else if (eligible) dvi_q <= dvi;
  end

  assign dvi_eff = eligible ? dvi : dvi_q;
  assign sb_nxt  = rise && !eligible && !dvi;
`else
  assign dvi_eff = 1'b0;
  assign sb_nxt  = rise && !eligible;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_prev   <= 1'b0;
      blank_cnt <= BLANK_MAX;
    end else begin
      de_prev <= bus.de;
      if (bus.de) blank_cnt <= '0;
      else if (blank_cnt != BLANK_MAX) blank_cnt <= blank_cnt + 4'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    case (state)
      CTL: begin
        if (eligible) state_nxt = PRE;
        else if (de_d) state_nxt = VIDEO;
      end
      PRE: begin
        if (cnt == 3'(PREAMBLE_LEN - 1)) state_nxt = GUARD;
        else cnt_nxt = cnt + 3'd1;
      end
      GUARD: begin
        if (cnt == 3'(GUARD_LEN - 1)) state_nxt = de_d ? VIDEO : CTL;
        else cnt_nxt = cnt + 3'd1;
      end
      VIDEO: begin
        // a 10-cycle gap lets the next preamble start right after the last pixel
        if (!de_d) state_nxt = eligible ? PRE : CTL;
      end
      default: state_nxt = CTL;
    endcase
    period_nxt = state_nxt;
    if (dvi_eff && (state_nxt == PRE || state_nxt == GUARD)) period_nxt = CTL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= CTL;
      cnt             <= '0;
      bus.period      <= CTL;
      bus.de_o        <= 1'b0;
      bus.pixel_o     <= '0;
      bus.ctl0        <= '0;
      bus.ctl1        <= '0;
      bus.ctl2        <= '0;
      bus.short_blank <= 1'b0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      bus.period      <= period_nxt;
      bus.de_o        <= (state_nxt == VIDEO);
      bus.pixel_o     <= (state_nxt == VIDEO) ? pix_d : '0;
      bus.ctl0        <= (state_nxt == VIDEO) ? 2'b00 : {vs_d, hs_d};
      bus.ctl1        <= (period_nxt == PRE) ? VIDEO_PREAMBLE_CTL1 : 2'b00;
      bus.ctl2        <= (period_nxt == PRE) ? VIDEO_PREAMBLE_CTL2 : 2'b00;
      bus.short_blank <= sb_nxt;
    end
  end

endmodule

// File: tb/tb_h14tx_period_sched.sv
// Self-checking bench for h14tx_period_sched against a history-based period model.
module tb_h14tx_period_sched;
  import h14tx_pkg::*;

  localparam int PW   = 24;
  localparam int NMAX = 4096;
  localparam int LAT  = LEAD + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic dvi   = 1'b0;

  always #5 clk = ~clk;

  h14tx_period_sched_if #(.PIXEL_W(PW)) bus ();

  h14tx_period_sched #(.PIXEL_W(PW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef H14TX_DVI_MODE_EN
    .dvi   (dvi),
`endif
    .bus   (bus)
  );

  logic          de_h  [NMAX];
  logic          hs_h  [NMAX];
  logic          vs_h  [NMAX];
  logic          dvi_h [NMAX];
  logic [PW-1:0] pix_h [NMAX];

  int n = 0;
  int epoch = 0;
  int checks = 0;
  int failures = 0;
  bit rel_pending = 1'b1;

  // input history as seen since the last reset release; anything earlier is blank
  function automatic logic hde(int i);
    if (i < epoch || i < 0 || i >= NMAX) return 1'b0;
    return de_h[i];
  endfunction

  function automatic logic [1:0] hsv(int i);
    if (i < epoch || i < 0 || i >= NMAX) return 2'b00;
    return {vs_h[i], hs_h[i]};
  endfunction

  function automatic int gap(int k);
    int g = 0;
    for (int j = 1; j <= LEAD; j++) begin
      if (hde(k - j)) return g;
      g++;
    end
    return g;
  endfunction

  function automatic logic is_rise(int k);
    return hde(k) && !hde(k - 1);
  endfunction

  function automatic period_t exp_period(int m);
    if (hde(m - LAT)) return VIDEO;
    for (int d = 1; d <= LEAD; d++) begin
      if (is_rise(m - d) && gap(m - d) == LEAD) begin
        if (dvi_h[m - d]) return CTL;
        return (d <= PREAMBLE_LEN) ? PRE : GUARD;
      end
    end
    return CTL;
  endfunction

  function automatic logic exp_short(int m);
    return is_rise(m - 1) && gap(m - 1) < LEAD && !dvi_h[m - 1];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  task automatic check_cycle();
    period_t p;
    int src;
    p   = exp_period(n);
    src = n - LAT;
    chk("period", 32'(bus.period), 32'(p));
    chk("de_o", 32'(bus.de_o), 32'(p == VIDEO));
    chk("pixel_o", 32'(bus.pixel_o), (p == VIDEO) ? 32'(pix_h[src]) : 32'd0);
    chk("ctl0", 32'(bus.ctl0), (p == VIDEO) ? 32'd0 : 32'(hsv(src)));
    chk("ctl1", 32'(bus.ctl1), (p == PRE) ? 32'd1 : 32'd0);
    chk("ctl2", 32'(bus.ctl2), 32'd0);
    chk("short_blank", 32'(bus.short_blank), 32'(exp_short(n)));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_period"}, 32'(bus.period), 32'(CTL));
    chk({tag, "_de_o"}, 32'(bus.de_o), 32'd0);
    chk({tag, "_pixel_o"}, 32'(bus.pixel_o), 32'd0);
    chk({tag, "_ctl0"}, 32'(bus.ctl0), 32'd0);
    chk({tag, "_ctl1"}, 32'(bus.ctl1), 32'd0);
    chk({tag, "_ctl2"}, 32'(bus.ctl2), 32'd0);
    chk({tag, "_short"}, 32'(bus.short_blank), 32'd0);
  endtask

  task automatic step(input logic d, input logic hs, input logic vs, input logic [PW-1:0] px);
    @(negedge clk);
    if (rel_pending) begin
      rst_n = 1'b1;
      epoch = n;
      rel_pending = 1'b0;
    end
    check_cycle();
    bus.de    = d;
    bus.hsync = hs;
    bus.vsync = vs;
    bus.pixel = px;
    de_h[n]  = d;
    hs_h[n]  = hs;
    vs_h[n]  = vs;
    pix_h[n] = px;
`ifdef H14TX_DVI_MODE_EN
    dvi_h[n] = dvi;
`else
    dvi_h[n] = 1'b0;
`endif
    n++;
  endtask

  task automatic blank(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, i[0], 1'b0, '0);
  endtask

  task automatic run(input int cycles, input logic [PW-1:0] px);
    for (int i = 0; i < cycles; i++) step(1'b1, 1'b0, 1'b0, px);
  endtask

  // asserts reset between an input drive and the next clock edge; held across one edge
  task automatic reset_pulse();
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    rel_pending = 1'b1;
  endtask

  initial begin
    bus.de = 1'b0;
    bus.hsync = 1'b0;
    bus.vsync = 1'b0;
    bus.pixel = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");

    // blanking with toggling sync, then a normal 4-pixel line
    for (int i = 0; i < 20; i++) step(1'b0, i[0], i[2], '0);
    blank(12);
    run(4, 24'h112233);
    // exactly 10-cycle gap: eligible, preamble abuts previous video
    blank(10);
    run(3, 24'h445566);
    // 5-cycle gap: no preamble, short_blank pulse
    blank(5);
    run(4, 24'h778899);
    // single-pixel line
    blank(12);
    run(1, 24'hABCDEF);
    // reset in the middle of a preamble, then a rise one cycle after release
    blank(12);
    run(3, 24'h010203);
    blank(2);
    reset_pulse();
    blank(1);
    run(3, 24'h0A0B0C);
    blank(14);

`ifdef H14TX_DVI_MODE_EN
    dvi = 1'b1;
    run(4, 24'h112233);
    blank(5);
    run(2, 24'h334455);
    blank(12);
    dvi = 1'b0;
`endif

    for (int s = 0; s < 40; s++) begin
      int g;
      int r;
      g = (s % 5 == 0) ? 10 : int'($urandom_range(1, 14));
      r = int'($urandom_range(1, 6));
`ifdef H14TX_DVI_MODE_EN
      dvi = 1'($urandom_range(0, 1));
`endif
      for (int i = 0; i < g; i++) step(1'b0, 1'($urandom), 1'($urandom), '0);
      for (int i = 0; i < r; i++) step(1'b1, 1'($urandom), 1'($urandom), PW'($urandom));
    end
    blank(25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cycle=%0d", n);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
